// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the binary/BCD converter slice.
//   state_t        : converter FSM states (IDLE, RUN, DONE)
//   MODE_*         : conversion direction encodings for in_mode
//   digits_needed  : minimum BCD digit count able to hold 2^width - 1
//   digit_valid    : true when a nibble is a legal decimal digit (0..9)
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_BIN2BCD = 1'b0;
    localparam logic MODE_BCD2BIN = 1'b1;

    // Smallest d with 10^d >= 2^width, i.e. 10^d > 2^width - 1.
    // Exact for widths that fit a 64-bit power of two; beyond that a
    // ceil(width * log10(2)) approximation is used.
    function automatic int unsigned digits_needed(input int unsigned width);
        longint unsigned lim;
        longint unsigned p;
        int unsigned     d;
        if (width >= 63) begin
            return (width * 30103 + 99999) / 100000;
        end
        lim = longint'(1) << width;
        p   = 1;
        d   = 0;
        while (p < lim) begin
            p = p * 10;
            d = d + 1;
        end
        return d;
    endfunction

    function automatic logic digit_valid(input logic [3:0] nibble);
        return nibble <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_converter_if.sv
// -----------------------------------------------------------------------------
// bcd_converter_if
// Request/response bundle of the binary/BCD converter.
//   in_valid/in_ready : request handshake; in_mode selects direction,
//                       in_bin / in_bcd carry the operand
//   out_valid/out_ready : result handshake; out_bin / out_bcd carry the
//                       result (the unconverted side echoes the operand),
//                       out_err / out_ovf flag BCD->binary problems
// Modports: master = requester/consumer side, slave = converter side.
// -----------------------------------------------------------------------------
interface bcd_converter_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode;
    logic [WIDTH-1:0]      in_bin;
    logic [4*DIGITS-1:0]   in_bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_bin;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_err;
    logic                  out_ovf;

    modport master (
        output in_valid, in_mode, in_bin, in_bcd, out_ready,
        input  in_ready, out_valid, out_bin, out_bcd, out_err, out_ovf
    );

    modport slave (
        input  in_valid, in_mode, in_bin, in_bcd, out_ready,
        output in_ready, out_valid, out_bin, out_bcd, out_err, out_ovf
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Double-dabble digit correction: adds 3 to a BCD digit that is >= 5 so the
// following left shift carries correctly into the next decimal digit.
//   digit_i : BCD digit before correction
//   digit_o : corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);
    always_comb begin
        digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
    end
endmodule

// File: rtl/bcd_converter.sv
// -----------------------------------------------------------------------------
// bcd_converter
// Multi-cycle bidirectional binary <-> BCD converter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bcd_converter_if.slave (request/response handshakes and data)
// Mode 0 runs WIDTH double-dabble iterations, mode 1 runs DIGITS
// multiply-by-ten iterations (MSD first). Results are registered on entry
// to DONE and held until the next DONE.
// -----------------------------------------------------------------------------
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    bcd_converter_if.slave bus
);

    localparam int unsigned BW   = 4 * DIGITS;
    localparam int unsigned SW   = BW + WIDTH;
    // Accumulator never loses overflow: 10^DIGITS < 16^DIGITS = 2^BW.
    localparam int unsigned AW   = BW + WIDTH;
    localparam int unsigned MAXN = (WIDTH > DIGITS) ? WIDTH : DIGITS;
    localparam int unsigned CW   = $clog2(MAXN + 1);

    if (WIDTH < 1) begin : g_width_err
        $error("bcd_converter: WIDTH must be at least 1");
    end
    if (DIGITS < digits_needed(WIDTH)) begin : g_digits_err
        $error("bcd_converter: DIGITS too small for WIDTH");
    end

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic            err_q, err_d;
    logic [SW-1:0]   sh_q, sh_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0] op_bin_q, op_bin_d;
    logic [BW-1:0]   op_bcd_q, op_bcd_d;
    logic [WIDTH-1:0] out_bin_q, out_bin_d;
    logic [BW-1:0]   out_bcd_q, out_bcd_d;
    logic            out_err_q, out_err_d;
    logic            out_ovf_q, out_ovf_d;

    logic            load_en;
    logic            iter_en;
    logic            last_iter;
    logic            in_ready;
    logic            out_valid;

    logic [BW-1:0]   bcd_adj;
    logic [SW-1:0]   sh_step;
    logic [3:0]      cur_digit;
    logic [AW-1:0]   acc_step;
    logic            acc_ovf;
    logic            any_invalid;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)          state_d = RUN;
            RUN:     if (cnt_q == CW'(1))       state_d = DONE;
            DONE:    if (bus.out_ready)         state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load_en   = 1'b0;
        iter_en   = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                load_en  = bus.in_valid;
            end
            RUN: begin
                iter_en   = 1'b1;
                last_iter = (cnt_q == CW'(1));
            end
            DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Datapath: iteration step ----------------
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (sh_q[WIDTH + 4*g +: 4]),
            .digit_o (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        // Mode 0 shifts {bcd, bin}; mode 1 reuses the same register to
        // stream BCD digits out of its top nibble, MSD first.
        if (mode_q == MODE_BIN2BCD) begin
            sh_step = {bcd_adj, sh_q[WIDTH-1:0]} << 1;
        end else begin
            sh_step = sh_q << 4;
        end
        cur_digit = sh_q[SW-1 -: 4];
        acc_step  = (acc_q << 3) + (acc_q << 1) + AW'(cur_digit);
        acc_ovf   = |acc_step[AW-1:WIDTH];
    end

    always_comb begin
        any_invalid = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!digit_valid(bus.in_bcd[4*i +: 4])) begin
                any_invalid = 1'b1;
            end
        end
    end

    // ---------------- Datapath: next state ----------------
    always_comb begin
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        err_d     = err_q;
        sh_d      = sh_q;
        acc_d     = acc_q;
        op_bin_d  = op_bin_q;
        op_bcd_d  = op_bcd_q;
        out_bin_d = out_bin_q;
        out_bcd_d = out_bcd_q;
        out_err_d = out_err_q;
        out_ovf_d = out_ovf_q;

        if (load_en) begin
            mode_d   = bus.in_mode;
            op_bin_d = bus.in_bin;
            op_bcd_d = bus.in_bcd;
            acc_d    = '0;
            if (bus.in_mode == MODE_BCD2BIN) begin
                cnt_d = CW'(DIGITS);
                sh_d  = {bus.in_bcd, {WIDTH{1'b0}}};
                err_d = any_invalid;
            end else begin
                cnt_d = CW'(WIDTH);
                sh_d  = {{BW{1'b0}}, bus.in_bin};
                err_d = 1'b0;
            end
        end else if (iter_en) begin
            cnt_d = cnt_q - CW'(1);
            sh_d  = sh_step;
            acc_d = acc_step;
            if (last_iter) begin
                if (mode_q == MODE_BIN2BCD) begin
                    out_bin_d = op_bin_q;
                    out_bcd_d = sh_step[SW-1 -: BW];
                    out_err_d = 1'b0;
                    out_ovf_d = 1'b0;
                end else begin
                    out_bcd_d = op_bcd_q;
                    out_err_d = err_q;
                    if (err_q) begin
                        out_bin_d = '0;
                        out_ovf_d = 1'b0;
                    end else if (acc_ovf) begin
                        out_bin_d = '1;
                        out_ovf_d = 1'b1;
                    end else begin
                        out_bin_d = acc_step[WIDTH-1:0];
                        out_ovf_d = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- Datapath: registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            mode_q    <= MODE_BIN2BCD;
            err_q     <= 1'b0;
            sh_q      <= '0;
            acc_q     <= '0;
            op_bin_q  <= '0;
            op_bcd_q  <= '0;
            out_bin_q <= '0;
            out_bcd_q <= '0;
            out_err_q <= 1'b0;
            out_ovf_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
            sh_q      <= sh_d;
            acc_q     <= acc_d;
            op_bin_q  <= op_bin_d;
            op_bcd_q  <= op_bcd_d;
            out_bin_q <= out_bin_d;
            out_bcd_q <= out_bcd_d;
            out_err_q <= out_err_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_bin   = out_bin_q;
    assign bus.out_bcd   = out_bcd_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_bcd_converter
// Scoreboard bench for bcd_converter with WIDTH = 8, DIGITS = 3.
// -----------------------------------------------------------------------------
module tb_bcd_converter;
    import bcd_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned D = 3;

    typedef struct {
        logic        mode;
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic        err;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_converter_if #(.WIDTH(W), .DIGITS(D)) bus ();

    bcd_converter #(.WIDTH(W), .DIGITS(D)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int unsigned cyc   = 0;
    int unsigned k_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic mode, input logic [7:0] bin, input logic [11:0] bcd);
        exp_t        e;
        int unsigned v;
        logic [3:0]  nib;
        e.mode = mode;
        e.err  = 1'b0;
        e.ovf  = 1'b0;
        if (mode == MODE_BIN2BCD) begin
            v     = int'(bin);
            e.bin = bin;
            e.bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        end else begin
            v     = 0;
            e.bcd = bcd;
            for (int i = 2; i >= 0; i--) begin
                nib = bcd[4*i +: 4];
                if (nib > 4'd9) e.err = 1'b1;
                v = v * 10 + int'(nib);
            end
            if (e.err)        e.bin = 8'h00;
            else if (v > 255) begin e.bin = 8'hFF; e.ovf = 1'b1; end
            else              e.bin = 8'(v);
        end
        return e;
    endfunction

    task automatic send(input logic mode, input logic [7:0] bin, input logic [11:0] bcd);
        bit done = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_bin   = bin;
        bus.in_bcd   = bcd;
        for (int t = 0; t < 50 && !done; t++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                k_acc = cyc;
                bus.in_valid = 1'b0;
                sb_q.push_back(model(mode, bin, bcd));
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            chk("accept_timeout", 32'(0), 32'(1));
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_out(output logic [11:0] bcd_seen, output logic [7:0] bin_seen);
        exp_t e;
        bit   got      = 0;
        bit   busy_bad = 0;
        bcd_seen = '0;
        bin_seen = '0;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'(0), 32'(1));
            return;
        end
        e = sb_q.pop_front();
        for (int t = 0; t < 50 && !got; t++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) got = 1;
            else if (bus.in_ready) busy_bad = 1;
        end
        if (!got) begin
            chk("out_timeout", 32'(0), 32'(1));
            return;
        end
        chk("busy_ready", 32'(busy_bad), 32'(0));
        chk("latency", 32'(cyc - k_acc), (e.mode == MODE_BIN2BCD) ? 32'(W) : 32'(D));
        chk("out_bin", 32'(bus.out_bin), 32'(e.bin));
        chk("out_bcd", 32'(bus.out_bcd), 32'(e.bcd));
        chk("out_err", 32'(bus.out_err), 32'(e.err));
        chk("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
        bcd_seen = bus.out_bcd;
        bin_seen = bus.out_bin;
    endtask

    task automatic ack();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("ack_valid", 32'(bus.out_valid), 32'(0));
        chk("ack_ready", 32'(bus.in_ready), 32'(1));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'(1));
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
        chk({tag, "_out_bin"},   32'(bus.out_bin),   32'(0));
        chk({tag, "_out_bcd"},   32'(bus.out_bcd),   32'(0));
        chk({tag, "_out_err"},   32'(bus.out_err),   32'(0));
        chk({tag, "_out_ovf"},   32'(bus.out_ovf),   32'(0));
    endtask

    initial begin
        logic [11:0] bcd_r, bcd_r2;
        logic [7:0]  bin_r, bin_r2;
        int unsigned m;

        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_bin    = '0;
        bus.in_bcd    = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed conversions
        send(MODE_BIN2BCD, 8'd255, 12'h000); wait_out(bcd_r, bin_r); ack();
        send(MODE_BIN2BCD, 8'd0,   12'h000); wait_out(bcd_r, bin_r); ack();
        send(MODE_BCD2BIN, 8'd0,   12'h199); wait_out(bcd_r, bin_r); ack();
        send(MODE_BCD2BIN, 8'd0,   12'h300); wait_out(bcd_r, bin_r); ack();
        send(MODE_BCD2BIN, 8'd0,   12'h1A3); wait_out(bcd_r, bin_r); ack();
        send(MODE_BCD2BIN, 8'd0,   12'h255); wait_out(bcd_r, bin_r); ack();
        send(MODE_BCD2BIN, 8'd0,   12'h256); wait_out(bcd_r, bin_r); ack();

        // Backpressure: DONE held with a competing request pending
        send(MODE_BCD2BIN, 8'd0, 12'h199);
        wait_out(bcd_r, bin_r);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_mode  = MODE_BIN2BCD;
        bus.in_bin   = 8'd77;
        bus.in_bcd   = 12'h000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(bus.out_valid), 32'(1));
            chk("bp_ready", 32'(bus.in_ready),  32'(0));
            chk("bp_bin",   32'(bus.out_bin),   32'(199));
            chk("bp_bcd",   32'(bus.out_bcd),   32'(12'h199));
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        m = cyc;
        bus.out_ready = 1'b0;
        chk("bp_hs_valid", 32'(bus.out_valid), 32'(0));
        chk("bp_hs_ready", 32'(bus.in_ready),  32'(1));
        @(posedge clk);
        #1;
        k_acc = cyc;
        bus.in_valid = 1'b0;
        chk("bp_accepted", 32'(bus.in_ready), 32'(0));
        chk("bp_accept_edge", 32'(k_acc), 32'(m + 1));
        sb_q.push_back(model(MODE_BIN2BCD, 8'd77, 12'h000));
        wait_out(bcd_r, bin_r);
        ack();

        // Reset during iteration 4 of a mode-0 run
        send(MODE_BIN2BCD, 8'd200, 12'h000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        void'(sb_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        send(MODE_BIN2BCD, 8'd42, 12'h000); wait_out(bcd_r, bin_r); ack();
        chk("post_rst_bcd", 32'(bcd_r), 32'(12'h042));

        // Round-trip sweep
        for (int v = 0; v < 256; v++) begin
            send(MODE_BIN2BCD, 8'(v), 12'h000);
            wait_out(bcd_r, bin_r);
            ack();
            send(MODE_BCD2BIN, 8'd0, bcd_r);
            wait_out(bcd_r2, bin_r2);
            ack();
            chk("rt_bin", 32'(bin_r2), 32'(v));
        end

        chk("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
